r2_cutoff_buffer: RTL and testbench
===================================

Name: r2_cutoff_buffer

Overview:
- Sits directly downstream of the r2 computation stage, one instance per r2 pipeline.
- Each cycle it checks whether r2 is inside the cutoff radius. Pairs with 0 < r2 < cutoff² are kept; all others are dropped.
- Kept pairs (r2, dx, dy, dz, neighbour tag) go into a show-ahead FIFO that feeds the force-evaluation pipeline over a valid/ready handshake.
- It raises almost_full early enough to stall the upstream enable, and it counts accepted and dropped pairs.

Parameters:
- DATA_WIDTH, 32, FP32 word width (from md_pkg; must stay 32 for the compare rules below).
- TAG_WIDTH, 16, width of the neighbour particle id carried with each pair.
- DEPTH, 64, FIFO entries; must be a power of two, ≥ 32.
- AF_MARGIN, 20, free-entry margin for almost_full. Covers the 17-cycle upstream latency plus 3 cycles of slack.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous clear of FIFO, stage register, counters and overflow flag
- cutoff2  in  DATA_WIDTH  FP32 squared cutoff; positive; held static while pairs are in flight
- r2_valid  in  1  r2, d_in and in_tag are valid this cycle
- r2  in  DATA_WIDTH  FP32 squared distance
- d_in  in  data_tuple_t  dx/dy/dz, aligned with r2
- in_tag  in  TAG_WIDTH  neighbour id, aligned with r2
- almost_full  out  1  upstream must deassert its enable while this is high
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head
- out_r2  out  DATA_WIDTH  head r2
- d_out  out  data_tuple_t  head dx/dy/dz
- out_tag  out  TAG_WIDTH  head tag
- accept_cnt  out  CNT_WIDTH  number of pairs written to the FIFO
- drop_cnt  out  CNT_WIDTH  number of pairs rejected by the filter
- overflow  out  1  sticky: a kept pair was lost because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous) and flush (synchronous) have the same effect:
  - FIFO emptied, stage register invalid, both counters 0, overflow 0.
  - Outputs: out_valid=0, almost_full=0, out_r2/d_out/out_tag=0.
- Filter rule, as a pure bit compare (non-negative FP32 bit patterns order the same way as their values):
  - keep = (r2[31]==0) && (r2[30:0]!=0) && (r2[30:23]!=8'hFF) && (r2[30:0] < cutoff2[30:0]).
  - So -0, +0, negative values, NaN, Inf and r2==cutoff2 are all dropped.
- Stage 1, edge N with r2_valid=1:
  - keep, r2, d_in and in_tag are registered.
  - drop_cnt increments at edge N if keep=0.
- Stage 2, edge N+1 with the stage register valid and keep=1:
  - Push into the FIFO and increment accept_cnt.
  - out_valid is high after edge N+1 when the FIFO was empty, giving a 2-cycle latency from input to output.
- FIFO, show-ahead:
  - Pop occurs when out_valid && out_ready at an edge.
  - Head outputs are stable while out_valid=1 and out_ready=0.
  - Pointers are log2(DEPTH) bits and wrap naturally; occupancy is held in a count register of log2(DEPTH)+1 bits.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full: count is unchanged and the entry is accepted.
- Push when full with no pop:
  - Entry is discarded, overflow is set (sticky), and accept_cnt does not increment.
- almost_full = (count ≥ DEPTH−AF_MARGIN). It is registered, i.e. it reflects the count after the current edge.
- Counters wrap modulo 2^CNT_WIDTH.
- flush coincident with r2_valid or a stage-2 push:
  - flush wins; the pair is neither stored nor counted.
- cutoff2 is sampled in stage 1 only.
- No combinational path from out_ready to any output other than through registered FIFO state.

Test Plan:
- Basic accept: cutoff2=0x41100000 (9.0), r2=0x40800000 (4.0), tag=5, out_ready=1 → out_valid high exactly 2 cycles later; out_r2=0x40800000, out_tag=5, d_out equal to d_in; accept_cnt=1.
- Filter boundaries: with the same cutoff, feed r2 = 0x41100000, 0x41200000, 0x00000000, 0x80000000, 0x7FC00000, 0x7F800000, 0xC0000000 → nothing reaches the output; drop_cnt=7, accept_cnt=0.
- Backpressure: out_ready=0; feed 44 kept pairs back-to-back → almost_full rises once count reaches 44; order is preserved when out_ready goes to 1; tags 0..43 emerge in sequence.
- Overflow: out_ready=0; feed 70 kept pairs → count saturates at 64, overflow=1, accept_cnt=64. Then hold out_ready=1 for 64 cycles → out_valid drops after the 64th pop and the FIFO is empty.
- Full with concurrent pop: FIFO full and out_ready=1 while pushing every cycle for 200 cycles → no overflow; pointers wrap at least 3 times; output sequence equals the input sequence.
- Reset and flush mid-operation: with 10 entries queued and a pair in stage 1, pulse rst_n low asynchronously (and, separately, flush for 1 cycle) → all outputs 0 immediately or next edge respectively; the in-flight pair never appears.

Source files
------------

// File: rtl/r2_cutoff_buffer.sv
// Keeps pairs with 0 < r2 < cutoff2 and queues them in a show-ahead FIFO; 2-cycle input-to-head latency.
// No input stall: almost_full (registered) throttles upstream; a kept pair arriving at a full FIFO is dropped and flagged.
package md_pkg;
    localparam int DATA_WIDTH = 32;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] dx;
        logic [DATA_WIDTH-1:0] dy;
        logic [DATA_WIDTH-1:0] dz;
    } data_tuple_t;
endpackage

module r2_cutoff_buffer #(
    parameter int DATA_WIDTH = md_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = 16,
    parameter int DEPTH      = 64,
    parameter int AF_MARGIN  = 20,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] cutoff2,
    input  logic                  r2_valid,
    input  logic [DATA_WIDTH-1:0] r2,
    input  md_pkg::data_tuple_t   d_in,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  almost_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r2,
    output md_pkg::data_tuple_t   d_out,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [CNT_WIDTH-1:0]  accept_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + $bits(md_pkg::data_tuple_t) + TAG_WIDTH;
    localparam logic [AW:0] AF_LEVEL   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic          keep;
    logic          unused_sign;
    logic          s1_vld;
    logic          s1_keep;
    logic [EW-1:0] s1_dat;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [EW-1:0] head;

    // Non-negative FP32 patterns order like unsigned integers, so magnitude bits compare directly.
    assign keep = !r2[31] && (r2[30:0] != '0) && (r2[30:23] != 8'hFF)
                  && (r2[30:0] < cutoff2[30:0]);
    assign unused_sign = cutoff2[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_keep <= 1'b0;
            s1_dat  <= '0;
        end else if (flush) begin
            s1_vld  <= 1'b0;
            s1_keep <= 1'b0;
        end else begin
            s1_vld <= r2_valid;
            if (r2_valid) begin
                s1_keep <= keep;
                s1_dat  <= {r2, d_in, in_tag};
            end
        end
    end

    assign out_valid = (count != '0);
    assign full      = (count == FULL_LEVEL);
    assign push      = s1_vld && s1_keep;
    assign pop       = out_valid && out_ready;
    // At full, a same-cycle pop frees the slot the write lands in.
    assign wr_en     = push && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!wr_en && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            accept_cnt  <= '0;
            drop_cnt    <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            accept_cnt  <= '0;
            drop_cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                accept_cnt <= accept_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_LEVEL);
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (r2_valid && !keep) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= s1_dat;
        end
    end

    // Storage is not reset, so the head is forced to zero whenever the FIFO is empty.
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_r2, d_out, out_tag} = head;

endmodule

// File: tb/tb_r2_cutoff_buffer.sv
// Scenario bench for r2_cutoff_buffer: expected pairs are queued on drive and compared on pop.
module tb_r2_cutoff_buffer;

    typedef struct packed {
        logic [31:0]         r2;
        md_pkg::data_tuple_t d;
        logic [15:0]         tag;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [31:0]         cutoff2;
    logic                r2_valid;
    logic [31:0]         r2;
    md_pkg::data_tuple_t d_in;
    logic [15:0]         in_tag;
    logic                almost_full;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_r2;
    md_pkg::data_tuple_t d_out;
    logic [15:0]         out_tag;
    logic [31:0]         accept_cnt;
    logic [31:0]         drop_cnt;
    logic                overflow;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] CUT9 = 32'h41100000;

    r2_cutoff_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cutoff2(cutoff2),
        .r2_valid(r2_valid), .r2(r2), .d_in(d_in), .in_tag(in_tag),
        .almost_full(almost_full), .out_valid(out_valid), .out_ready(out_ready),
        .out_r2(out_r2), .d_out(d_out), .out_tag(out_tag),
        .accept_cnt(accept_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic md_pkg::data_tuple_t mk_d(input logic [15:0] t, input logic [31:0] r);
        md_pkg::data_tuple_t d;
        d.dx = {16'hA000, t};
        d.dy = {16'hB000, t};
        d.dz = r ^ 32'h5555_5555;
        return d;
    endfunction

    function automatic entry_t mk_e(input logic [15:0] t, input logic [31:0] r);
        entry_t e;
        e.r2  = r;
        e.d   = mk_d(t, r);
        e.tag = t;
        return e;
    endfunction

    function automatic logic [31:0] kept_r2(input int k);
        return 32'h3F800000 + 32'(k << 4);
    endfunction

    // One cycle: sample the head (pop happens at the coming edge if ready), then drive new inputs.
    task automatic step(input bit v, input logic [31:0] r, input logic [15:0] t, input bit rdy,
                        output bit popped, output entry_t head);
        @(negedge clk);
        out_ready = rdy;
        popped    = out_valid && rdy;
        head.r2   = out_r2;
        head.d    = d_out;
        head.tag  = out_tag;
        r2_valid  = v;
        r2        = r;
        in_tag    = t;
        d_in      = mk_d(t, r);
    endtask

    task automatic do_flush();
        @(negedge clk);
        r2_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; cutoff2 = CUT9; r2_valid = 1'b0; r2 = '0;
        in_tag = '0; d_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", accept_cnt, drop_cnt); end
        checks++; if ({out_r2, d_out, out_tag} !== '0) begin errors++; $display("FAIL reset_head: got %h expected 0", {out_r2, d_out, out_tag}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_accept();
        bit p; entry_t h; entry_t e;
        do_flush();
        step(1'b1, 32'h40800000, 16'd5, 1'b1, p, h);
        sb.push_back(mk_e(16'd5, 32'h40800000));
        step(1'b0, '0, '0, 1'b1, p, h);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid %b expected 0", out_valid); end
        step(1'b0, '0, '0, 1'b1, p, h);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b expected 1", out_valid); end
        if (p && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (h !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", h, e); end
        end
        checks++; if (accept_cnt !== 32'd1) begin errors++; $display("FAIL basic_accept_cnt: got %0d expected 1", accept_cnt); end
        step(1'b0, '0, '0, 1'b1, p, h);
        checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL basic_drain: out_valid %b left %0d expected 0/0", out_valid, sb.size()); end
    endtask

    task automatic test_filter();
        bit p; entry_t h;
        logic [31:0] vals [7] = '{32'h41100000, 32'h41200000, 32'h00000000, 32'h80000000,
                                  32'h7FC00000, 32'h7F800000, 32'hC0000000};
        do_flush();
        for (int k = 0; k < 10; k++) begin
            step(k < 7, (k < 7) ? vals[k] : 32'h0, 16'(k), 1'b1, p, h);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL filter_leak: out_valid %b expected 0 at step %0d", out_valid, k); end
        end
        checks++; if (drop_cnt !== 32'd7) begin errors++; $display("FAIL filter_drop_cnt: got %0d expected 7", drop_cnt); end
        checks++; if (accept_cnt !== 32'd0) begin errors++; $display("FAIL filter_accept_cnt: got %0d expected 0", accept_cnt); end
    endtask

    task automatic test_backpressure();
        bit p; entry_t h; entry_t e; int n;
        do_flush();
        for (int k = 0; k < 46; k++) begin
            step(k < 44, kept_r2(k), 16'(k), 1'b0, p, h);
            if (k < 44) sb.push_back(mk_e(16'(k), kept_r2(k)));
            n = (k < 1) ? 0 : ((k - 1 > 44) ? 44 : k - 1);
            checks++; if (almost_full !== (n >= 44)) begin errors++; $display("FAIL bp_almost_full: got %b expected %b at count %0d", almost_full, (n >= 44), n); end
        end
        checks++; if (accept_cnt !== 32'd44) begin errors++; $display("FAIL bp_accept_cnt: got %0d expected 44", accept_cnt); end
        for (int k = 0; k < 80 && sb.size() > 0; k++) begin
            step(1'b0, '0, '0, 1'b1, p, h);
            if (p) begin
                e = sb.pop_front();
                checks++; if (h !== e) begin errors++; $display("FAIL bp_order: got tag %0d expected tag %0d (%h vs %h)", h.tag, e.tag, h, e); end
            end
        end
        step(1'b0, '0, '0, 1'b1, p, h);
        checks++; if (sb.size() != 0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL bp_drain: left %0d out_valid %b almost_full %b expected 0/0/0", sb.size(), out_valid, almost_full);
        end
    endtask

    task automatic test_overflow();
        bit p; entry_t h; entry_t e; int pops;
        do_flush();
        for (int k = 0; k < 72; k++) begin
            step(k < 70, kept_r2(k), 16'(100 + k), 1'b0, p, h);
            if (k < 64) sb.push_back(mk_e(16'(100 + k), kept_r2(k)));
            if (k == 65) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0 at exactly full", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (accept_cnt !== 32'd64) begin errors++; $display("FAIL ovf_accept_cnt: got %0d expected 64", accept_cnt); end
        checks++; if (almost_full !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_full_state: af %b out_valid %b expected 1/1", almost_full, out_valid); end
        pops = 0;
        for (int k = 0; k < 64; k++) begin
            step(1'b0, '0, '0, 1'b1, p, h);
            if (p && sb.size() > 0) begin
                pops++;
                e = sb.pop_front();
                checks++; if (h !== e) begin errors++; $display("FAIL ovf_order: got %h expected %h", h, e); end
            end
        end
        step(1'b0, '0, '0, 1'b1, p, h);
        checks++; if (pops != 64 || out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: pops %0d out_valid %b expected 64/0", pops, out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_concurrent();
        bit p; entry_t h; entry_t e; int pops;
        do_flush();
        pops = 0;
        for (int k = 0; k < 264; k++) begin
            step(1'b1, kept_r2(k), 16'(1000 + k), k >= 65, p, h);
            sb.push_back(mk_e(16'(1000 + k), kept_r2(k)));
            if (p) begin
                pops++;
                e = sb.pop_front();
                checks++; if (h !== e) begin errors++; $display("FAIL conc_order: got %h expected %h", h, e); end
            end
        end
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            step(1'b0, '0, '0, 1'b1, p, h);
            if (p) begin
                pops++;
                e = sb.pop_front();
                checks++; if (h !== e) begin errors++; $display("FAIL conc_order: got %h expected %h", h, e); end
            end
        end
        checks++; if (pops != 264 || sb.size() != 0) begin errors++; $display("FAIL conc_count: pops %0d left %0d expected 264/0", pops, sb.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL conc_overflow: got %b expected 0", overflow); end
        checks++; if (accept_cnt !== 32'd264) begin errors++; $display("FAIL conc_accept_cnt: got %0d expected 264", accept_cnt); end
    endtask

    task automatic fill_ten();
        bit p; entry_t h;
        do_flush();
        for (int k = 0; k < 12; k++) begin
            step(k < 10, kept_r2(k), 16'(2000 + k), 1'b0, p, h);
        end
        checks++; if (accept_cnt !== 32'd10 || out_valid !== 1'b1) begin errors++; $display("FAIL midop_fill: accept %0d out_valid %b expected 10/1", accept_cnt, out_valid); end
    endtask

    task automatic test_reset_flush_midop();
        bit p; entry_t h;
        fill_ten();
        step(1'b1, kept_r2(50), 16'd999, 1'b0, p, h);
        @(posedge clk);
        #2;
        r2_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_flags: out_valid %b af %b ovf %b expected 0", out_valid, almost_full, overflow); end
        checks++; if (accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL arst_counters: got %0d/%0d expected 0/0", accept_cnt, drop_cnt); end
        checks++; if ({out_r2, d_out, out_tag} !== '0) begin errors++; $display("FAIL arst_head: got %h expected 0", {out_r2, d_out, out_tag}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, '0, 1'b1, p, h);
            checks++; if (out_valid !== 1'b0 || accept_cnt !== 32'd0) begin errors++; $display("FAIL arst_inflight: out_valid %b accept %0d expected 0/0", out_valid, accept_cnt); end
        end

        fill_ten();
        step(1'b1, kept_r2(60), 16'd998, 1'b0, p, h);
        step(1'b1, 32'h41200000, 16'd997, 1'b0, p, h);
        flush = 1'b1;
        step(1'b0, '0, '0, 1'b0, p, h);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL flush_flags: out_valid %b af %b ovf %b expected 0", out_valid, almost_full, overflow); end
        checks++; if (accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL flush_counters: got %0d/%0d expected 0/0", accept_cnt, drop_cnt); end
        checks++; if ({out_r2, d_out, out_tag} !== '0) begin errors++; $display("FAIL flush_head: got %h expected 0", {out_r2, d_out, out_tag}); end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, '0, 1'b1, p, h);
            checks++; if (out_valid !== 1'b0 || accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
                errors++; $display("FAIL flush_inflight: out_valid %b accept %0d drop %0d expected 0/0/0", out_valid, accept_cnt, drop_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_accept();
        test_filter();
        test_backpressure();
        test_overflow();
        test_full_concurrent();
        test_reset_flush_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
